ahb_rr_arbiter: RTL and testbench

Round-robin AHB bus arbiter sharing one AHB address/data bus between up to `NUM_MST` masters. It sits in front of the AHB-to-APB bridge. It watches the shared bus `htrans`/`hburst`/`hready`/`hresp`, registers `hgrant`, and drives the `hmaster`/`hmaster_data` select indices for the address and write-data muxes. It honours fixed-length bursts and locked sequences, and parks the bus on a default master when no one requests.

---
 rtl/ahb_rr_arbiter.sv | 148 ++++++++++++++
 tb/tb_ahb_rr_arbiter.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/ahb_rr_arbiter.sv
// ahb_rr_arbiter: round-robin arbiter for a shared AHB bus.
// Registers the one-hot grant and drives the address-phase (hmaster) and
// data-phase (hmaster_data) owner indices plus hmastlock. Fixed-length
// bursts and locked sequences are never split. With no requests the bus
// parks on DEF_MST.
module ahb_rr_arbiter #(
  parameter int NUM_MST = 4,
  parameter int DEF_MST = 0,
  parameter int MW      = (NUM_MST > 1) ? $clog2(NUM_MST) : 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_MST-1:0] hbusreq,
  input  logic [NUM_MST-1:0] hlock,
  input  logic [1:0]         htrans,
  input  logic [2:0]         hburst,
  input  logic               hready,
  input  logic               hresp,
  output logic [NUM_MST-1:0] hgrant,
  output logic [MW-1:0]      hmaster,
  output logic [MW-1:0]      hmaster_data,
  output logic               hmastlock
);

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

  localparam logic [NUM_MST-1:0] DEF_GNT = NUM_MST'(1) << DEF_MST;
  localparam logic [MW-1:0]      DEF_IDX = MW'(DEF_MST);

  typedef enum logic [1:0] {
    ST_PARK,
    ST_GRANT,
    ST_BURST,
    ST_LOCK
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [MW-1:0]      ptr_q, ptr_d;
  logic [NUM_MST-1:0] grant_d;
  logic [MW-1:0]      owner;
  logic               lock_own;
  logic               handover_pend;
  logic               rr_hit;
  logic [MW-1:0]      rr_idx;

  // Remaining beats after a NONSEQ of the given burst type (beats - 1).
  function automatic logic [3:0] burst_beats_m1(input logic [2:0] burst);
    case (burst)
      3'b010, 3'b011: burst_beats_m1 = 4'd3;
      3'b100, 3'b101: burst_beats_m1 = 4'd7;
      3'b110, 3'b111: burst_beats_m1 = 4'd15;
      default:        burst_beats_m1 = 4'd0;
    endcase
  endfunction

  // Owner is the index of the set grant bit.
  always_comb begin
    owner = '0;
    for (int i = 0; i < NUM_MST; i++) begin
      if (hgrant[i]) owner = MW'(i);
    end
  end

  assign lock_own      = hlock[owner];
  // A newly granted master has not yet had its address phase; keep its
  // grant through the one-cycle handover so it cannot be pre-empted.
  assign handover_pend = (hmaster != owner);

  // Beat counter next value: error clears it, accepted beats load/decrement.
  always_comb begin
    cnt_d = cnt_q;
    if (hresp && !hready) begin
      cnt_d = 4'd0;
    end else if (hready) begin
      case (htrans)
        TR_NONSEQ: cnt_d = burst_beats_m1(hburst);
        TR_SEQ:    cnt_d = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
        TR_IDLE:   cnt_d = 4'd0;
        default:   cnt_d = cnt_q;
      endcase
    end
  end

  // Round-robin search starting after the pointer; pointer index is checked last.
  always_comb begin
    rr_hit = 1'b0;
    rr_idx = DEF_IDX;
    for (int i = 1; i <= NUM_MST; i++) begin
      logic [MW-1:0] cand;
      cand = MW'((int'(ptr_q) + i) % NUM_MST);
      if (!rr_hit && hbusreq[cand]) begin
        rr_hit = 1'b1;
        rr_idx = cand;
      end
    end
  end

  // Next state, grant and pointer; everything holds on wait states.
  always_comb begin
    state_d = state_q;
    grant_d = hgrant;
    ptr_d   = ptr_q;
    if (hready) begin
      if (lock_own) begin
        state_d = ST_LOCK;
      end else if (cnt_d != 4'd0) begin
        state_d = ST_BURST;
      end else if (handover_pend) begin
        state_d = ST_GRANT;
      end else if (rr_hit) begin
        grant_d         = '0;
        grant_d[rr_idx] = 1'b1;
        ptr_d           = rr_idx;
        state_d         = ST_GRANT;
      end else begin
        grant_d = DEF_GNT;
        state_d = ST_PARK;
      end
    end
  end

  // Arbiter state, counter and bus-owner pipelines.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_PARK;
      cnt_q        <= 4'd0;
      ptr_q        <= DEF_IDX;
      hgrant       <= DEF_GNT;
      hmaster      <= DEF_IDX;
      hmaster_data <= DEF_IDX;
      hmastlock    <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
      hgrant  <= grant_d;
      ptr_q   <= ptr_d;
      if (hready) begin
        hmaster      <= owner;
        hmaster_data <= hmaster;
        hmastlock    <= lock_own;
      end
    end
  end

endmodule

// File: tb/tb_ahb_rr_arbiter.sv
// tb_ahb_rr_arbiter: directed bus scenarios with a queue of expected outputs.
module tb_ahb_rr_arbiter;

  localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NS = 2'b10, SQ = 2'b11;
  localparam logic [2:0] SINGLE = 3'b000, INCR = 3'b001, INCR4 = 3'b011,
                         INCR8 = 3'b101, INCR16 = 3'b111;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] hbusreq, hlock;
  logic [1:0] htrans;
  logic [2:0] hburst;
  logic       hready, hresp;
  logic [3:0] hgrant;
  logic [1:0] hmaster, hmaster_data;
  logic       hmastlock;

  ahb_rr_arbiter #(.NUM_MST(4), .DEF_MST(0)) dut (
    .clk(clk), .reset_n(reset_n), .hbusreq(hbusreq), .hlock(hlock),
    .htrans(htrans), .hburst(hburst), .hready(hready), .hresp(hresp),
    .hgrant(hgrant), .hmaster(hmaster), .hmaster_data(hmaster_data),
    .hmastlock(hmastlock)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] g;
    logic [1:0] m;
    logic [1:0] md;
    logic       ml;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input logic [3:0] g, input logic [1:0] m,
                          input logic [1:0] md, input logic ml);
    exp_t e;
    e.g = g; e.m = m; e.md = md; e.ml = ml;
    sb.push_back(e);
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, ".sb_empty"}, 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, ".hgrant"},       32'(hgrant),       32'(e.g));
      chk({tag, ".hmaster"},      32'(hmaster),      32'(e.m));
      chk({tag, ".hmaster_data"}, 32'(hmaster_data), 32'(e.md));
      chk({tag, ".hmastlock"},    32'(hmastlock),    32'(e.ml));
    end
  endtask

  // Drive one bus cycle, queue what the outputs must be after the edge, compare.
  task automatic step(input string tag, input logic [3:0] req, input logic [3:0] lk,
                      input logic [1:0] tr, input logic [2:0] bu, input logic rdy,
                      input logic rsp, input logic [3:0] eg, input logic [1:0] em,
                      input logic [1:0] emd, input logic eml);
    hbusreq = req; hlock = lk; htrans = tr; hburst = bu; hready = rdy; hresp = rsp;
    push_exp(eg, em, emd, eml);
    @(posedge clk);
    #1;
    check_out(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    hbusreq = '0; hlock = '0; htrans = IDLE; hburst = SINGLE; hready = 1'b1; hresp = 1'b0;

    // Reset held with no requests.
    for (int i = 0; i < 5; i++)
      step("reset", 4'b0000, 4'b0000, IDLE, SINGLE, 1'b1, 1'b0, 4'b0001, 2'd0, 2'd0, 1'b0);
    chk("reset.cnt", 32'(dut.cnt_q), 32'd0);
    reset_n = 1'b1;
    step("park", 4'b0000, 4'b0000, IDLE, SINGLE, 1'b1, 1'b0, 4'b0001, 2'd0, 2'd0, 1'b0);

    // From PARK, M1 and M2 request; M1 wins, then M2 after M1's SINGLE.
    step("m1_gnt",   4'b0110, 4'b0000, IDLE, SINGLE, 1'b1, 1'b0, 4'b0010, 2'd0, 2'd0, 1'b0);
    step("m1_hand",  4'b0110, 4'b0000, IDLE, SINGLE, 1'b1, 1'b0, 4'b0010, 2'd1, 2'd0, 1'b0);
    step("m1_single",4'b0100, 4'b0000, NS,   SINGLE, 1'b1, 1'b0, 4'b0100, 2'd1, 2'd1, 1'b0);
    step("m2_hand",  4'b0100, 4'b0000, IDLE, SINGLE, 1'b1, 1'b0, 4'b0100, 2'd2, 2'd1, 1'b0);

    // M2 INCR4 with a wait state and a BUSY, M3 requesting throughout.
    step("i4_b1",    4'b1100, 4'b0000, NS,   INCR4, 1'b1, 1'b0, 4'b0100, 2'd2, 2'd2, 1'b0);
    chk("i4_b1.cnt", 32'(dut.cnt_q), 32'd3);
    step("i4_wait",  4'b1100, 4'b0000, SQ,   INCR4, 1'b0, 1'b0, 4'b0100, 2'd2, 2'd2, 1'b0);
    chk("i4_wait.cnt", 32'(dut.cnt_q), 32'd3);
    step("i4_b2",    4'b1100, 4'b0000, SQ,   INCR4, 1'b1, 1'b0, 4'b0100, 2'd2, 2'd2, 1'b0);
    step("i4_busy",  4'b1100, 4'b0000, BUSY, INCR4, 1'b1, 1'b0, 4'b0100, 2'd2, 2'd2, 1'b0);
    chk("i4_busy.cnt", 32'(dut.cnt_q), 32'd2);
    step("i4_b3",    4'b1100, 4'b0000, SQ,   INCR4, 1'b1, 1'b0, 4'b0100, 2'd2, 2'd2, 1'b0);
    step("i4_b4",    4'b1100, 4'b0000, SQ,   INCR4, 1'b1, 1'b0, 4'b1000, 2'd2, 2'd2, 1'b0);
    chk("i4_b4.cnt", 32'(dut.cnt_q), 32'd0);
    step("m3_hand",  4'b1000, 4'b0000, IDLE, SINGLE, 1'b1, 1'b0, 4'b1000, 2'd3, 2'd2, 1'b0);

    // M1 locked for three INCR transfers while M0 and M2 request.
    step("m1_req",   4'b0010, 4'b0000, IDLE, SINGLE, 1'b1, 1'b0, 4'b0010, 2'd3, 2'd3, 1'b0);
    step("m1_lkhand",4'b0010, 4'b0010, IDLE, SINGLE, 1'b1, 1'b0, 4'b0010, 2'd1, 2'd3, 1'b1);
    for (int i = 0; i < 3; i++)
      step("lock_incr", 4'b0111, 4'b0010, NS, INCR, 1'b1, 1'b0, 4'b0010, 2'd1, 2'd1, 1'b1);
    step("unlock",   4'b0101, 4'b0000, IDLE, SINGLE, 1'b1, 1'b0, 4'b0100, 2'd1, 2'd1, 1'b0);
    step("m2_hand2", 4'b0101, 4'b0000, IDLE, SINGLE, 1'b1, 1'b0, 4'b0100, 2'd2, 2'd1, 1'b0);

    // M3 INCR8 hit by a two-cycle ERROR after beat 3, M0 requesting.
    step("m3_req",   4'b1000, 4'b0000, IDLE, SINGLE, 1'b1, 1'b0, 4'b1000, 2'd2, 2'd2, 1'b0);
    step("m3_hand2", 4'b1001, 4'b0000, IDLE, SINGLE, 1'b1, 1'b0, 4'b1000, 2'd3, 2'd2, 1'b0);
    step("i8_b1",    4'b1001, 4'b0000, NS,   INCR8, 1'b1, 1'b0, 4'b1000, 2'd3, 2'd3, 1'b0);
    step("i8_b2",    4'b1001, 4'b0000, SQ,   INCR8, 1'b1, 1'b0, 4'b1000, 2'd3, 2'd3, 1'b0);
    step("i8_b3",    4'b1001, 4'b0000, SQ,   INCR8, 1'b1, 1'b0, 4'b1000, 2'd3, 2'd3, 1'b0);
    chk("i8_b3.cnt", 32'(dut.cnt_q), 32'd5);
    step("err1",     4'b1001, 4'b0000, SQ,   INCR8, 1'b0, 1'b1, 4'b1000, 2'd3, 2'd3, 1'b0);
    chk("err1.cnt", 32'(dut.cnt_q), 32'd0);
    step("err2",     4'b1001, 4'b0000, IDLE, INCR8, 1'b1, 1'b1, 4'b0001, 2'd3, 2'd3, 1'b0);
    step("m0_hand",  4'b0001, 4'b0000, IDLE, SINGLE, 1'b1, 1'b0, 4'b0001, 2'd0, 2'd3, 1'b0);

    // M2 INCR16, reset asserted at beat 6.
    step("m2_req3",  4'b0100, 4'b0000, IDLE, SINGLE, 1'b1, 1'b0, 4'b0100, 2'd0, 2'd0, 1'b0);
    step("m2_hand3", 4'b0100, 4'b0000, IDLE, SINGLE, 1'b1, 1'b0, 4'b0100, 2'd2, 2'd0, 1'b0);
    step("i16_b1",   4'b0100, 4'b0000, NS,   INCR16, 1'b1, 1'b0, 4'b0100, 2'd2, 2'd2, 1'b0);
    for (int i = 0; i < 5; i++)
      step("i16_seq", 4'b0100, 4'b0000, SQ, INCR16, 1'b1, 1'b0, 4'b0100, 2'd2, 2'd2, 1'b0);
    chk("i16_b6.cnt", 32'(dut.cnt_q), 32'd10);
    reset_n = 1'b0;
    push_exp(4'b0001, 2'd0, 2'd0, 1'b0);
    #1;
    check_out("async_rst");
    chk("async_rst.cnt", 32'(dut.cnt_q), 32'd0);
    step("rst_hold", 4'b1010, 4'b0000, IDLE, SINGLE, 1'b1, 1'b0, 4'b0001, 2'd0, 2'd0, 1'b0);
    reset_n = 1'b1;
    // Pointer back at 0: M1 is found before M3.
    step("restart",  4'b1010, 4'b0000, IDLE, SINGLE, 1'b1, 1'b0, 4'b0010, 2'd0, 2'd0, 1'b0);
    step("restart_h",4'b1010, 4'b0000, IDLE, SINGLE, 1'b1, 1'b0, 4'b0010, 2'd1, 2'd0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
